popcount_ingress: RTL and testbench
===================================

// Module: popcount_ingress
//
// PURPOSE
//   Ingress stage directly upstream of the popcount counter.
//   - Merges two word sources into one AXI4-Stream toward popcount: DMA stream words and single MMIO writes.
//   - Zeroes bytes not flagged by TKEEP, so downstream counts only valid bytes.
//   - Buffers words in a DEPTH-entry FIFO and keeps DMA packets contiguous (no MMIO word lands mid-packet).
//   - Reports occupancy, drops, packet completion and busy to the MMIO register block.
//
// PARAMETERS
//   DEPTH   8   FIFO entries; power of two, >= 2
//
// PORTS
//   S_AXIS_ACLK     in   1              single clock, all logic rising-edge
//   S_AXIS_ARESET   in   1              reset, synchronous, active-high
//   S_AXIS_TDATA    in   32             DMA data word
//   S_AXIS_TKEEP    in   4              byte valid flags; bit i covers TDATA[8i+7:8i]
//   S_AXIS_TLAST    in   1              last beat of DMA transfer
//   S_AXIS_TVALID   in   1              DMA beat valid
//   S_AXIS_TREADY   out  1              beat accepted when TVALID&TREADY
//   WRITE_DATA      in   32             MMIO word
//   WRITE_VALID     in   1              one-cycle MMIO write strobe; no backpressure
//   WRITE_DROP      out  1              one-cycle pulse: an MMIO write was discarded
//   FLUSH           in   1              one-cycle request: empty FIFO and abort current packet
//   M_AXIS_TDATA    out  32             word to popcount
//   M_AXIS_TLAST    out  1              word ends a transfer
//   M_AXIS_TVALID   out  1              FIFO non-empty
//   M_AXIS_TREADY   in   1              popcount accepts word
//   LEVEL           out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//   PKT_DONE        out  1              one-cycle pulse: a TLAST word was popped
//   BUSY            out  1              ingress active or holding data
//
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//
//   Reset
//   - While S_AXIS_ARESET=1: state=IDLE, FIFO empty.
//   - Outputs 0 during reset: S_AXIS_TREADY, M_AXIS_TVALID, WRITE_DROP, PKT_DONE, LEVEL, BUSY.
//   - M_AXIS_TDATA and M_AXIS_TLAST are don't-care while M_AXIS_TVALID=0.
//   - Reset mid-packet discards everything; the next accepted beat is treated as a packet start.
//
//   Storage
//   - Each FIFO entry is {last, data}.
//   - DMA entries store TDATA with byte i zeroed when TKEEP[i]=0, plus TLAST.
//   - MMIO entries store WRITE_DATA with last=1; each MMIO write is a one-word transfer.
//   - full = (LEVEL==DEPTH), empty = (LEVEL==0), both from registered state.
//   - No push when full, even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle: LEVEL unchanged.
//   - Pointers wrap modulo DEPTH.
//   - Latency: a word pushed in cycle N gives M_AXIS_TVALID=1 in N+1. No bypass path.
//
//   Output handshake
//   - M_AXIS_TVALID = !empty. Data shows the head entry.
//   - The head entry is held stable while TVALID & !TREADY.
//   - Pop on TVALID & TREADY.
//   - PKT_DONE is asserted in the cycle after popping an entry with last=1.
//
//   FSM states
//   - IDLE: between transfers.
//     - WRITE_VALID & !full & !FLUSH: push the MMIO word. S_AXIS_TREADY=0 that cycle (MMIO has priority).
//     - Otherwise S_AXIS_TREADY = !full & !FLUSH.
//     - Accepted beat with TLAST=0: go to IN_PKT. Accepted beat with TLAST=1: stay in IDLE.
//   - IN_PKT: inside a DMA transfer.
//     - S_AXIS_TREADY = !full & !FLUSH.
//     - Every MMIO write is dropped.
//     - Accepted beat with TLAST=1: go to IDLE.
//   - DISCARD: draining the rest of an aborted transfer.
//     - S_AXIS_TREADY=1; beats are accepted but not stored.
//     - Every MMIO write is dropped.
//     - Accepted beat with TLAST=1: go to IDLE.
//
//   Flush
//   - The FLUSH cycle empties the FIFO; LEVEL=0 in the next cycle.
//   - Any pop in that cycle is ignored: no PKT_DONE.
//   - S_AXIS_TREADY=0 that cycle.
//   - State after flush: IN_PKT goes to DISCARD; IDLE stays IDLE; DISCARD stays DISCARD.
//
//   Drops
//   - WRITE_DROP is registered and pulses in the cycle after a WRITE_VALID that was not pushed.
//   - Causes: full, IN_PKT, DISCARD, or FLUSH=1.
//
//   BUSY = (state != IDLE) | !empty.
//
// TESTING
//   1. After reset: 3 DMA beats, TKEEP=F, data FFFFFFFF/0000000F/80000001, last on beat 3, TREADY=1.
//      -> same words out in order; TLAST on the 3rd; PKT_DONE pulses once; LEVEL returns to 0; BUSY=0.
//   2. DMA beat TDATA=FFFFFFFF, TKEEP=4'b0101.
//      -> M_AXIS_TDATA=00FF00FF.
//   3. WRITE_VALID with 12345678 in IDLE, same cycle as a DMA beat.
//      -> MMIO word out first with TLAST=1; the DMA beat is accepted one cycle later.
//   4. M_AXIS_TREADY=0, then DEPTH+2 DMA beats offered.
//      -> S_AXIS_TREADY=0 once LEVEL=8; a WRITE_VALID in that window gives WRITE_DROP=1 next cycle; no data lost.
//   5. Mid-packet (IN_PKT): WRITE_VALID.
//      -> dropped, WRITE_DROP pulses; packet stays contiguous.
//   6. FLUSH after 2 of 5 beats.
//      -> LEVEL=0; beats 3-5 accepted and discarded; state returns to IDLE after TLAST; BUSY=0 after that.

Source files
------------

// File: rtl/popcount_ingress_if.sv
// Bundle of stream, MMIO and status signals between the ingress stage and its neighbours.
// The slave modport is the ingress block's view; master is the surrounding system's view.
interface popcount_ingress_if #(
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [31:0]   S_AXIS_TDATA;
   logic [3:0]    S_AXIS_TKEEP;
   logic          S_AXIS_TLAST;
   logic          S_AXIS_TVALID;
   logic          S_AXIS_TREADY;
   logic [31:0]   WRITE_DATA;
   logic          WRITE_VALID;
   logic          WRITE_DROP;
   logic          FLUSH;
   logic [31:0]   M_AXIS_TDATA;
   logic          M_AXIS_TLAST;
   logic          M_AXIS_TVALID;
   logic          M_AXIS_TREADY;
   logic [LW-1:0] LEVEL;
   logic          PKT_DONE;
   logic          BUSY;

   modport slave (
      input  S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID,
      output S_AXIS_TREADY,
      input  WRITE_DATA, WRITE_VALID, FLUSH,
      output WRITE_DROP,
      output M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TVALID,
      input  M_AXIS_TREADY,
      output LEVEL, PKT_DONE, BUSY
   );

   modport master (
      output S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID,
      input  S_AXIS_TREADY,
      output WRITE_DATA, WRITE_VALID, FLUSH,
      input  WRITE_DROP,
      input  M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TVALID,
      output M_AXIS_TREADY,
      input  LEVEL, PKT_DONE, BUSY
   );
endinterface

// File: rtl/popcount_ingress.sv
// Ingress stage ahead of popcount: merges DMA beats and MMIO words into one stream,
// masks invalid bytes, and keeps DMA packets contiguous in a DEPTH-entry FIFO.
//
// state   | meaning
// IDLE    | between transfers; MMIO writes accepted, priority over DMA
// IN_PKT  | inside a DMA transfer; MMIO writes dropped
// DISCARD | draining the remainder of a flushed transfer; beats accepted, not stored
module popcount_ingress #(
   parameter int DEPTH = 8
) (
   input  logic                S_AXIS_ACLK,
   input  logic                S_AXIS_ARESET,
   popcount_ingress_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_t;

   state_t         state_q, state_d;
   logic [32:0]    mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]  level_q;
   logic           drop_q, drop_d;
   logic           pkt_done_q;
   logic           full, empty, push, pop, tready;
   logic [31:0]    masked, push_data;
   logic           push_last;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   // A flush discards the head, so it must not count as a pop (no PKT_DONE).
   assign pop   = !empty && bus.M_AXIS_TREADY && !bus.FLUSH;

   always_comb begin
      masked = '0;
      for (int i = 0; i < 4; i++)
         masked[8*i +: 8] = bus.S_AXIS_TKEEP[i] ? bus.S_AXIS_TDATA[8*i +: 8] : 8'h00;
   end

   always_comb begin
      state_d   = state_q;
      tready    = 1'b0;
      push      = 1'b0;
      push_data = masked;
      push_last = bus.S_AXIS_TLAST;
      drop_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.WRITE_VALID && !full && !bus.FLUSH) begin
               push      = 1'b1;
               push_data = bus.WRITE_DATA;
               push_last = 1'b1;
            end else begin
               tready = !full && !bus.FLUSH;
               drop_d = bus.WRITE_VALID;
            end
            if (tready && bus.S_AXIS_TVALID) begin
               push = 1'b1;
               if (!bus.S_AXIS_TLAST) state_d = IN_PKT;
            end
         end
         IN_PKT: begin
            tready = !full && !bus.FLUSH;
            drop_d = bus.WRITE_VALID;
            if (tready && bus.S_AXIS_TVALID) begin
               push = 1'b1;
               if (bus.S_AXIS_TLAST) state_d = IDLE;
            end
            if (bus.FLUSH) state_d = DISCARD;
         end
         DISCARD: begin
            tready = !bus.FLUSH;
            drop_d = bus.WRITE_VALID;
            if (tready && bus.S_AXIS_TVALID && bus.S_AXIS_TLAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         drop_q     <= 1'b0;
         pkt_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         drop_q     <= drop_d;
         pkt_done_q <= pop && mem_q[rd_ptr_q][32];
         if (bus.FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
         end
      end
   end

   // Storage needs no reset: entries are only observed below the level count.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (push && !bus.FLUSH) mem_q[wr_ptr_q] <= {push_last, push_data};
   end

   assign bus.S_AXIS_TREADY = tready && !S_AXIS_ARESET;
   assign bus.M_AXIS_TVALID = !empty;
   assign bus.M_AXIS_TDATA  = mem_q[rd_ptr_q][31:0];
   assign bus.M_AXIS_TLAST  = mem_q[rd_ptr_q][32];
   assign bus.LEVEL         = level_q;
   assign bus.WRITE_DROP    = drop_q;
   assign bus.PKT_DONE      = pkt_done_q;
   assign bus.BUSY          = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_popcount_ingress.sv
// Directed bench for popcount_ingress: byte-mask vector table plus packet,
// arbitration, backpressure, drop and flush sequences.
module tb_popcount_ingress;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   popcount_ingress_if #(.DEPTH(DEPTH)) bus ();

   popcount_ingress #(.DEPTH(DEPTH)) dut (
      .S_AXIS_ACLK   (clk),
      .S_AXIS_ARESET (rst),
      .bus           (bus.slave)
   );

   typedef struct {
      logic [31:0] tdata;
      logic [3:0]  tkeep;
      logic [31:0] exp_data;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          pkt_cnt = 0;
   logic [32:0] cap_q [$];

   always @(negedge clk) begin
      if (!rst && bus.M_AXIS_TVALID && bus.M_AXIS_TREADY && !bus.FLUSH)
         cap_q.push_back({bus.M_AXIS_TLAST, bus.M_AXIS_TDATA});
      if (!rst && bus.PKT_DONE) pkt_cnt++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      n = 0;
      bus.S_AXIS_TDATA  = d;
      bus.S_AXIS_TKEEP  = k;
      bus.S_AXIS_TLAST  = l;
      bus.S_AXIS_TVALID = 1'b1;
      @(negedge clk);
      while (!bus.S_AXIS_TREADY && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_beat timeout: tready stayed 0 for data %0h", d);
      end
      @(posedge clk);
      #1;
      bus.S_AXIS_TVALID = 1'b0;
   endtask

   initial begin
      vec_t vecs [7];
      int   p0;
      vecs[0] = '{32'hFFFF_FFFF, 4'b0101, 32'h00FF_00FF};
      vecs[1] = '{32'hFFFF_FFFF, 4'b1010, 32'hFF00_FF00};
      vecs[2] = '{32'h1234_5678, 4'b1111, 32'h1234_5678};
      vecs[3] = '{32'h1234_5678, 4'b0001, 32'h0000_0078};
      vecs[4] = '{32'hDEAD_BEEF, 4'b1000, 32'hDE00_0000};
      vecs[5] = '{32'hDEAD_BEEF, 4'b0000, 32'h0000_0000};
      vecs[6] = '{32'hA5A5_A5A5, 4'b0110, 32'h00A5_A500};

      rst = 1'b1;
      bus.S_AXIS_TDATA  = '0;
      bus.S_AXIS_TKEEP  = '0;
      bus.S_AXIS_TLAST  = 1'b0;
      bus.S_AXIS_TVALID = 1'b1;
      bus.WRITE_DATA    = '0;
      bus.WRITE_VALID   = 1'b0;
      bus.FLUSH         = 1'b0;
      bus.M_AXIS_TREADY = 1'b0;
      cyc(3);
      chk("rst_tready",   64'(bus.S_AXIS_TREADY), 64'd0);
      chk("rst_tvalid",   64'(bus.M_AXIS_TVALID), 64'd0);
      chk("rst_level",    64'(bus.LEVEL), 64'd0);
      chk("rst_busy",     64'(bus.BUSY), 64'd0);
      chk("rst_drop",     64'(bus.WRITE_DROP), 64'd0);
      chk("rst_pkt_done", 64'(bus.PKT_DONE), 64'd0);
      bus.S_AXIS_TVALID = 1'b0;
      rst = 1'b0;
      cyc(1);

      // 3-beat packet through an always-ready sink
      cap_q.delete();
      p0 = pkt_cnt;
      bus.M_AXIS_TREADY = 1'b1;
      send_beat(32'hFFFF_FFFF, 4'hF, 1'b0);
      send_beat(32'h0000_000F, 4'hF, 1'b0);
      send_beat(32'h8000_0001, 4'hF, 1'b1);
      cyc(4);
      chk("t1_count", 64'(cap_q.size()), 64'd3);
      if (cap_q.size() == 3) begin
         chk("t1_w0", 64'(cap_q[0]), {31'd0, 1'b0, 32'hFFFF_FFFF});
         chk("t1_w1", 64'(cap_q[1]), {31'd0, 1'b0, 32'h0000_000F});
         chk("t1_w2", 64'(cap_q[2]), {31'd0, 1'b1, 32'h8000_0001});
      end
      chk("t1_pkt_done", 64'(pkt_cnt - p0), 64'd1);
      chk("t1_level", 64'(bus.LEVEL), 64'd0);
      chk("t1_busy",  64'(bus.BUSY), 64'd0);

      // byte-mask table: one single-beat transfer per entry
      foreach (vecs[i]) begin
         bus.M_AXIS_TREADY = 1'b0;
         p0 = pkt_cnt;
         send_beat(vecs[i].tdata, vecs[i].tkeep, 1'b1);
         chk($sformatf("mask%0d_valid", i), 64'(bus.M_AXIS_TVALID), 64'd1);
         chk($sformatf("mask%0d_data", i),  64'(bus.M_AXIS_TDATA), 64'(vecs[i].exp_data));
         chk($sformatf("mask%0d_last", i),  64'(bus.M_AXIS_TLAST), 64'd1);
         bus.M_AXIS_TREADY = 1'b1;
         cyc(3);
         chk($sformatf("mask%0d_done", i),  64'(pkt_cnt - p0), 64'd1);
      end

      // MMIO and DMA in the same IDLE cycle: MMIO wins
      cap_q.delete();
      bus.M_AXIS_TREADY = 1'b0;
      bus.WRITE_DATA    = 32'h1234_5678;
      bus.WRITE_VALID   = 1'b1;
      bus.S_AXIS_TDATA  = 32'hAAAA_5555;
      bus.S_AXIS_TKEEP  = 4'hF;
      bus.S_AXIS_TLAST  = 1'b1;
      bus.S_AXIS_TVALID = 1'b1;
      @(negedge clk);
      chk("t3_tready_mmio", 64'(bus.S_AXIS_TREADY), 64'd0);
      cyc(1);
      bus.WRITE_VALID = 1'b0;
      @(negedge clk);
      chk("t3_tready_next", 64'(bus.S_AXIS_TREADY), 64'd1);
      cyc(1);
      bus.S_AXIS_TVALID = 1'b0;
      chk("t3_level", 64'(bus.LEVEL), 64'd2);
      chk("t3_drop",  64'(bus.WRITE_DROP), 64'd0);
      bus.M_AXIS_TREADY = 1'b1;
      cyc(3);
      chk("t3_count", 64'(cap_q.size()), 64'd2);
      if (cap_q.size() == 2) begin
         chk("t3_w0", 64'(cap_q[0]), {31'd0, 1'b1, 32'h1234_5678});
         chk("t3_w1", 64'(cap_q[1]), {31'd0, 1'b1, 32'hAAAA_5555});
      end

      // fill to DEPTH with the sink stalled; MMIO while full is dropped
      cap_q.delete();
      p0 = pkt_cnt;
      bus.M_AXIS_TREADY = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         bus.S_AXIS_TDATA  = 32'h100 + 32'(i);
         bus.S_AXIS_TKEEP  = 4'hF;
         bus.S_AXIS_TLAST  = 1'b1;
         bus.S_AXIS_TVALID = 1'b1;
         bus.WRITE_VALID   = (i == DEPTH);
         bus.WRITE_DATA    = 32'hBAD0_BAD0;
         @(negedge clk);
         chk($sformatf("t4_tready%0d", i), 64'(bus.S_AXIS_TREADY), (i < DEPTH) ? 64'd1 : 64'd0);
         cyc(1);
         chk($sformatf("t4_drop%0d", i), 64'(bus.WRITE_DROP), (i == DEPTH) ? 64'd1 : 64'd0);
      end
      bus.S_AXIS_TVALID = 1'b0;
      bus.WRITE_VALID   = 1'b0;
      chk("t4_level_full", 64'(bus.LEVEL), 64'(DEPTH));
      bus.M_AXIS_TREADY = 1'b1;
      cyc(DEPTH + 3);
      chk("t4_count", 64'(cap_q.size()), 64'(DEPTH));
      for (int i = 0; i < DEPTH && i < cap_q.size(); i++)
         chk($sformatf("t4_w%0d", i), 64'(cap_q[i]), {31'd0, 1'b1, 32'h100 + 32'(i)});
      chk("t4_pkt_done", 64'(pkt_cnt - p0), 64'(DEPTH));
      chk("t4_level_empty", 64'(bus.LEVEL), 64'd0);

      // MMIO write inside a DMA packet is dropped
      cap_q.delete();
      p0 = pkt_cnt;
      send_beat(32'h1111_1111, 4'hF, 1'b0);
      bus.S_AXIS_TDATA  = 32'h2222_2222;
      bus.S_AXIS_TLAST  = 1'b0;
      bus.S_AXIS_TVALID = 1'b1;
      bus.WRITE_DATA    = 32'hCAFE_F00D;
      bus.WRITE_VALID   = 1'b1;
      @(negedge clk);
      chk("t5_tready", 64'(bus.S_AXIS_TREADY), 64'd1);
      cyc(1);
      bus.WRITE_VALID   = 1'b0;
      bus.S_AXIS_TVALID = 1'b0;
      chk("t5_drop", 64'(bus.WRITE_DROP), 64'd1);
      send_beat(32'h3333_3333, 4'hF, 1'b1);
      cyc(3);
      chk("t5_count", 64'(cap_q.size()), 64'd3);
      if (cap_q.size() == 3) begin
         chk("t5_w0", 64'(cap_q[0]), {31'd0, 1'b0, 32'h1111_1111});
         chk("t5_w1", 64'(cap_q[1]), {31'd0, 1'b0, 32'h2222_2222});
         chk("t5_w2", 64'(cap_q[2]), {31'd0, 1'b1, 32'h3333_3333});
      end
      chk("t5_pkt_done", 64'(pkt_cnt - p0), 64'd1);

      // flush after 2 of 5 beats, then drain the rest in DISCARD
      cap_q.delete();
      bus.M_AXIS_TREADY = 1'b0;
      send_beat(32'h0000_0001, 4'hF, 1'b0);
      send_beat(32'h0000_0002, 4'hF, 1'b0);
      chk("t6_level2", 64'(bus.LEVEL), 64'd2);
      bus.FLUSH = 1'b1;
      @(negedge clk);
      chk("t6_tready_flush", 64'(bus.S_AXIS_TREADY), 64'd0);
      cyc(1);
      bus.FLUSH = 1'b0;
      chk("t6_level0", 64'(bus.LEVEL), 64'd0);
      chk("t6_busy_discard", 64'(bus.BUSY), 64'd1);
      send_beat(32'h0000_0003, 4'hF, 1'b0);
      send_beat(32'h0000_0004, 4'hF, 1'b0);
      send_beat(32'h0000_0005, 4'hF, 1'b1);
      chk("t6_level_after", 64'(bus.LEVEL), 64'd0);
      chk("t6_busy_after", 64'(bus.BUSY), 64'd0);
      bus.M_AXIS_TREADY = 1'b1;
      send_beat(32'h0000_0006, 4'hF, 1'b1);
      cyc(2);
      chk("t6_count", 64'(cap_q.size()), 64'd1);
      if (cap_q.size() == 1)
         chk("t6_w0", 64'(cap_q[0]), {31'd0, 1'b1, 32'h0000_0006});

      // flush coinciding with a pop of a last word: no PKT_DONE
      cap_q.delete();
      bus.M_AXIS_TREADY = 1'b0;
      send_beat(32'h0000_0007, 4'hF, 1'b1);
      p0 = pkt_cnt;
      bus.M_AXIS_TREADY = 1'b1;
      bus.FLUSH = 1'b1;
      cyc(1);
      bus.FLUSH = 1'b0;
      cyc(2);
      chk("t7_pkt_done", 64'(pkt_cnt - p0), 64'd0);
      chk("t7_level", 64'(bus.LEVEL), 64'd0);
      chk("t7_count", 64'(cap_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
